serial_arith_left_shift_sat: RTL and testbench

Sequential signed multiply by 2^sh, i.e. the arithmetic left shift that undoes the arithmetic-right-shift / signed-divide family.
Shifts one bit per clock under a valid/ready handshake and detects signed overflow.
On overflow the result either saturates or wraps, depending on compile option.
Sits on the datapath side of the shift library as the scaling-up counterpart of the divide-by-2^S blocks.

---
 rtl/serial_arith_left_shift_sat_if.sv | 13 +
 rtl/serial_arith_left_shift_sat.sv | 56 +++++
 tb/tb_serial_arith_left_shift_sat.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serial_arith_left_shift_sat_if.sv
// serial_arith_left_shift_sat_if: operand/result handshake bundle for the serial arithmetic left shifter
interface serial_arith_left_shift_sat_if #(parameter int N = 8, parameter int SW = 3);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a;
  logic [SW-1:0] sh;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] res;
  logic ovf;
  modport master(output in_valid, a, sh, out_ready, input in_ready, out_valid, res, ovf);
  modport slave(input in_valid, a, sh, out_ready, output in_ready, out_valid, res, ovf);
endinterface

// File: rtl/serial_arith_left_shift_sat.sv
// serial_arith_left_shift_sat: signed a*2^sh one bit per clock with sticky overflow; wraps on overflow,
// or saturates when SERIAL_ALS_SATURATE_EN is defined
module serial_arith_left_shift_sat #(
  parameter int N = 8,
  parameter int SW = 3
) (
  input logic clk,
  input logic rst,
  serial_arith_left_shift_sat_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [N-1:0] acc;
  logic [SW-1:0] cnt;
  logic ovf;
  logic accept;
  assign accept = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (accept ? (bus.sh == '0 ? DONE : SHIFT) : IDLE) :
          state == SHIFT ? (cnt == SW'(1) ? DONE : SHIFT) :
          (bus.out_ready ? IDLE : DONE);
  // overflow whenever the bit about to become the sign differs from the current sign
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= bus.a;
      cnt <= bus.sh;
      ovf <= 1'b0;
    end else if (state == SHIFT) begin
      ovf <= ovf | (acc[N-1] ^ acc[N-2]);
      acc <= {acc[N-2:0], 1'b0};
      cnt <= cnt - SW'(1);
    end
`ifdef SERIAL_ALS_SATURATE_EN
  logic sign;
  always_ff @(posedge clk)
    if (rst) sign <= 1'b0;
    else if (accept) sign <= bus.a[N-1];
  logic [N-1:0] result;
  assign result = ovf ? (sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : acc;
`else
  logic [N-1:0] result;
  assign result = acc;
`endif
  always_comb begin
    bus.in_ready = state == IDLE && !rst;
    bus.out_valid = state == DONE;
    bus.res = result;
    bus.ovf = ovf;
  end
endmodule

// File: tb/tb_serial_arith_left_shift_sat.sv
// tb_serial_arith_left_shift_sat: directed and randomized checks against an integer-arithmetic model
module tb_serial_arith_left_shift_sat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;

  serial_arith_left_shift_sat_if #(.N(8), .SW(3)) bus ();
  serial_arith_left_shift_sat #(.N(8), .SW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic void model(input logic [7:0] av, input logic [2:0] shv,
                                output logic [7:0] r, output logic o);
    longint p;
    p = longint'($signed(av)) * (longint'(1) << shv);
    o = (p > 127) || (p < -128);
`ifdef SERIAL_ALS_SATURATE_EN
    r = o ? ($signed(av) < 0 ? 8'h80 : 8'h7F) : p[7:0];
`else
    r = p[7:0];
`endif
  endfunction

  task automatic xact(input logic [7:0] av, input logic [2:0] shv, input int hold, input bit junk,
                      output logic [7:0] r, output logic o, output int lat,
                      output bit stable, output bit ready_after);
    int w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus.in_valid = 1'b1; bus.a = av; bus.sh = shv;
    @(posedge clk); #1;
    bus.in_valid = junk; bus.a = ~av; bus.sh = ~shv;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    r = bus.res; o = bus.ovf; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.res !== r || bus.ovf !== o || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ready_after = bus.in_ready === 1'b1 && bus.out_valid === 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.a = '0; bus.sh = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.ovf, bus.res} !== 11'h0) begin
      n_err++; $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b res=%h want all 0",
                        bus.in_ready, bus.out_valid, bus.ovf, bus.res);
    end
    rst = 1'b0; #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [7:0] ta [6] = '{8'hFD, 8'h05, 8'd100, 8'h9C, 8'h00, 8'h40};
    logic [2:0] ts [6] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd1};
`ifdef SERIAL_ALS_SATURATE_EN
    logic [7:0] er [6] = '{8'hE8, 8'h05, 8'h7F, 8'h80, 8'h00, 8'h7F};
`else
    logic [7:0] er [6] = '{8'hE8, 8'h05, 8'hC8, 8'h70, 8'h00, 8'h80};
`endif
    logic eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] r; logic o; int lat; bit st, ra;
    for (int i = 0; i < 6; i++) begin
      xact(ta[i], ts[i], 0, 1'b0, r, o, lat, st, ra);
      n_cmp++;
      if (r !== er[i] || o !== eo[i]) begin
        n_err++; $display("FAIL directed_%0d: got res=%h ovf=%b want res=%h ovf=%b", i, r, o, er[i], eo[i]);
      end
      n_cmp++;
      if (lat != int'(ts[i])) begin n_err++; $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, ts[i]); end
      n_cmp++;
      if (!ra) begin n_err++; $display("FAIL directed_idle_%0d: got 0 want 1", i); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r; logic o; int lat; bit st, ra;
    xact(8'h01, 3'd6, 5, 1'b1, r, o, lat, st, ra);
    n_cmp++;
    if (r !== 8'h40 || o !== 1'b0) begin n_err++; $display("FAIL bp_result: got res=%h ovf=%b want res=40 ovf=0", r, o); end
    n_cmp++;
    if (!st) begin n_err++; $display("FAIL bp_hold: got 0 want 1 (stable outputs, in_ready low)"); end
    n_cmp++;
    if (!ra) begin n_err++; $display("FAIL bp_ready_after: got 0 want 1"); end
    xact(8'hFF, 3'd7, 0, 1'b1, r, o, lat, st, ra);
    n_cmp++;
    if (r !== 8'h80 || o !== 1'b0 || lat != 7) begin
      n_err++; $display("FAIL b2b_result: got res=%h ovf=%b lat=%0d want res=80 ovf=0 lat=7", r, o, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r; logic o; int lat; bit st, ra;
    bus.in_valid = 1'b1; bus.a = 8'd3; bus.sh = 3'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.ovf, bus.res} !== 11'h0) begin
      n_err++; $display("FAIL mid_reset_state: got rdy=%b vld=%b ovf=%b res=%h want all 0",
                        bus.in_ready, bus.out_valid, bus.ovf, bus.res);
    end
    rst = 1'b0; #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b want 1", bus.in_ready); end
    xact(8'd3, 3'd2, 0, 1'b0, r, o, lat, st, ra);
    n_cmp++;
    if (r !== 8'd12 || o !== 1'b0 || lat != 2) begin
      n_err++; $display("FAIL mid_reset_fresh: got res=%h ovf=%b lat=%0d want res=0c ovf=0 lat=2", r, o, lat);
    end
  endtask

  task automatic test_random;
    logic [7:0] av, r, er; logic [2:0] shv; logic o, eo; int lat; bit st, ra;
    for (int i = 0; i < 60; i++) begin
      av = 8'($urandom_range(0, 255));
      if (i % 10 == 0) av = 8'h00;
      if (i % 10 == 1) av = 8'h80;
      if (i % 10 == 2) av = 8'h7F;
      shv = 3'($urandom_range(0, 7));
      model(av, shv, er, eo);
      xact(av, shv, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), r, o, lat, st, ra);
      n_cmp++;
      if (r !== er || o !== eo || lat != int'(shv) || !st || !ra) begin
        n_err++;
        $display("FAIL random_%0d a=%h sh=%0d: got res=%h ovf=%b lat=%0d st=%b ra=%b want res=%h ovf=%b lat=%0d st=1 ra=1",
                 i, av, shv, r, o, lat, st, ra, er, eo, shv);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
